dma_engine: RTL and testbench
=============================

# dma_engine

External DMA engine that consumes the DMA command issued by the CPU-side DMA manager and moves a fixed-length block of words from the I/O device buffer into main memory. It latches the target address, requests the memory bus, streams `LENGTH` words into memory once granted, releases the bus, and then signals completion back to the manager with `dma_end`. It sits between the device buffer and the shared memory bus, directly downstream of the DMA manager.

## Interface
- `WORD_SIZE`, 16: data and address width.
- `LENGTH`, 12: words per transfer, 1..2^WORD_SIZE-1.
- `clk` input 1: single clock; all state changes on the rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `cmd_valid` input 1: command present on `cmd_addr`; sampled only in IDLE.
- `cmd_addr` input WORD_SIZE: base memory address (DMA manager's `dma_command`).
- `bus_grant` input 1: bus granted to this engine.
- `bus_request` output 1: request for the memory bus.
- `dev_index` output WORD_SIZE: device-buffer word index being read.
- `dev_data` input WORD_SIZE: device word at `dev_index`, combinational.
- `mem_addr` output WORD_SIZE: memory address; high-Z unless the engine is in XFER and granted.
- `mem_wdata` output WORD_SIZE: memory write data; high-Z unless the engine is in XFER and granted.
- `mem_write` output 1: memory write strobe.
- `mem_ack` input 1: memory accepted the current word at this edge.
- `dma_end` output 1: one-cycle completion pulse.
- `busy` output 1: high in every state except IDLE.

## Operation
- States: IDLE, REQ, XFER, RELEASE, END. Registers: `state`, `base`, `count`, `bus_request`, `dma_end`.
- **IDLE**
  - If `cmd_valid`=1: latch `base`=`cmd_addr`, set `count`=0, set `bus_request`=1, go to REQ.
- **REQ**
  - Hold `bus_request`=1.
  - When `bus_grant`=1: go to XFER.
- **XFER**
  - `mem_addr`=`base`+`count`, modulo 2^WORD_SIZE (wraps 0xFFFF to 0x0000).
  - `mem_wdata`=`dev_data`.
  - `dev_index`=`count`.
  - `mem_write`=`bus_grant`.
  - On `mem_ack`=1 with `bus_grant`=1:
    - If `count`=LENGTH-1: clear `bus_request`, go to RELEASE.
    - Otherwise: increment `count`.
  - If `bus_grant` drops mid-transfer: stall. Hold `count`, `mem_write`=0, bus outputs high-Z. Resume when the grant returns. `mem_ack` is ignored while ungranted.
- **RELEASE**
  - `bus_request`=0.
  - Wait for `bus_grant`=0, then set `dma_end`=1 and go to END.
- **END**
  - Clear `dma_end`, go to IDLE.
- `cmd_valid` is ignored outside IDLE. A command held high across END is accepted again only after a new IDLE cycle, so the DMA manager must withdraw it once it has been granted.
- `dev_index` outside XFER: drives `count`.
- Reset:
  - Asynchronously forces IDLE, `count`=0, `base`=0.
  - Outputs: `bus_request`=0, `mem_write`=0, `dma_end`=0, `busy`=0, `mem_addr`/`mem_wdata` high-Z, `dev_index`=0.
  - A reset mid-transfer abandons the block and drops `bus_request` immediately. No `dma_end` is issued.

## Timing
- `bus_request` rises at the edge after `cmd_valid` is seen in IDLE.
- First `mem_write` appears in the cycle after the edge at which `bus_grant`=1 is sampled in REQ.
- Throughput: one word per `mem_ack`.
  - Minimum transfer is LENGTH cycles in XFER, reached when `mem_ack` is high every cycle.
  - For a memory with fixed ack latency L: LENGTH×L cycles.
- `bus_request` falls at the same edge that accepts the last `mem_ack`.
- `dma_end` is registered and high for exactly one cycle.
  - It starts at the edge after `bus_grant`=0 is sampled in RELEASE.
  - This guarantees the DMA manager is already waiting for `dma_end` before it sees the pulse.
- Back-to-back: a new command can be accepted in the IDLE cycle immediately following END.

## Test plan
- **Nominal transfer.** Reset, then `cmd_addr`=0x01F4, `cmd_valid` pulse, grant after 2 cycles, `mem_ack` tied 1, `dev_data`=0xA000+`dev_index`.
  - Response: 12 writes, 0x01F4←0xA000 through 0x01FF←0xA00B.
  - `bus_request` low after the 12th ack; one `dma_end` pulse after the grant drops.
- **Slow memory.** Same as nominal, with `mem_ack` asserted every 3rd cycle.
  - Response: 12 writes with unchanged address/data ordering, each held stable until acked; 36 XFER cycles.
- **Grant revocation.** Drop `bus_grant` after the 5th ack for 4 cycles.
  - Response: `mem_write`=0 and bus outputs high-Z during the gap, `count` stays 5, then resumes at 0x01F9 and completes 12 writes.
- **Address wrap.** `cmd_addr`=0xFFFA.
  - Response: writes to 0xFFFA..0xFFFF, then 0x0000..0x0005.
- **Reset mid-operation.** Assert `reset_n`=0 after the 7th ack.
  - Response: outputs go to reset values asynchronously; no `dma_end`.
  - A following command at 0x0100 transfers a full 12 words starting at 0x0100.
- **Command ignored while busy, then back-to-back.** Pulse `cmd_valid` with 0x0300 during XFER.
  - Response: ignored; the first transfer is unaffected.
  - A second command asserted in the IDLE cycle right after END starts a full new transfer at its address.

Source files
------------

// File: rtl/dma_engine.sv
// dma_engine: moves a LENGTH-word block from the device buffer into memory.
// Ports: cmd_valid/cmd_addr start a block; bus_request/bus_grant own the
//   bus; dev_index/dev_data read the device; mem_addr/mem_wdata/mem_write/
//   mem_ack write memory (tri-stated when not owned); dma_end pulses once
//   after the bus is returned; busy is high outside IDLE.
module dma_engine #(
  parameter int WORD_SIZE = 16,
  parameter int LENGTH    = 12
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 cmd_valid,
  input  logic [WORD_SIZE-1:0] cmd_addr,
  input  logic                 bus_grant,
  output logic                 bus_request,
  output logic [WORD_SIZE-1:0] dev_index,
  input  logic [WORD_SIZE-1:0] dev_data,
  output logic [WORD_SIZE-1:0] mem_addr,
  output logic [WORD_SIZE-1:0] mem_wdata,
  output logic                 mem_write,
  input  logic                 mem_ack,
  output logic                 dma_end,
  output logic                 busy
);

  localparam logic [WORD_SIZE-1:0] LAST = WORD_SIZE'(LENGTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_XFER,
    S_REL,
    S_END
  } state_e;

  state_e               state_q, state_d;
  logic [WORD_SIZE-1:0] base_q, base_d;
  logic [WORD_SIZE-1:0] count_q, count_d;
  logic                 bus_request_q, bus_request_d;
  logic                 dma_end_q, dma_end_d;
  logic                 drive_bus;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      base_q        <= '0;
      count_q       <= '0;
      bus_request_q <= 1'b0;
      dma_end_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      base_q        <= base_d;
      count_q       <= count_d;
      bus_request_q <= bus_request_d;
      dma_end_q     <= dma_end_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    base_d        = base_q;
    count_d       = count_q;
    bus_request_d = bus_request_q;
    dma_end_d     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          base_d        = cmd_addr;
          count_d       = '0;
          bus_request_d = 1'b1;
          state_d       = S_REQ;
        end
      end
      S_REQ: begin
        bus_request_d = 1'b1;
        if (bus_grant) state_d = S_XFER;
      end
      S_XFER: begin
        // An ack only counts while we own the bus.
        if (bus_grant && mem_ack) begin
          if (count_q == LAST) begin
            bus_request_d = 1'b0;
            state_d       = S_REL;
          end else begin
            count_d = count_q + 1'b1;
          end
        end
      end
      S_REL: begin
        bus_request_d = 1'b0;
        // Pulse only once the arbiter has really taken the bus back.
        if (!bus_grant) begin
          dma_end_d = 1'b1;
          state_d   = S_END;
        end
      end
      S_END: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    drive_bus   = (state_q == S_XFER) && bus_grant;
    mem_write   = drive_bus;
    busy        = (state_q != S_IDLE);
    dev_index   = count_q;
    bus_request = bus_request_q;
    dma_end     = dma_end_q;
  end

  // Address wraps naturally at 2^WORD_SIZE.
  assign mem_addr  = drive_bus ? (base_q + count_q) : 'z;
  assign mem_wdata = drive_bus ? dev_data : 'z;

endmodule

// File: tb/tb_dma_engine.sv
// tb_dma_engine: randomized and directed checks of dma_engine
// against a transfer-level model of the block it must move.
module tb_dma_engine;
  localparam int W = 16;
  localparam int L = 12;

  logic         clk = 1'b0;
  logic         reset_n = 1'b1;
  logic         cmd_valid = 1'b0;
  logic [W-1:0] cmd_addr = '0;
  logic         bus_grant = 1'b0;
  logic         mem_ack = 1'b0;
  logic [W-1:0] dev_key = 16'hA000;
  logic         bus_request, mem_write, dma_end, busy;
  logic [W-1:0] dev_index, dev_data, mem_addr, mem_wdata;

  assign dev_data = dev_key + dev_index;

  dma_engine #(.WORD_SIZE(W), .LENGTH(L)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_addr(cmd_addr),
    .bus_grant(bus_grant), .bus_request(bus_request),
    .dev_index(dev_index), .dev_data(dev_data),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_write(mem_write), .mem_ack(mem_ack),
    .dma_end(dma_end), .busy(busy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transfer-level model: who holds the bus and how many words landed.
  typedef enum int {M_FREE, M_ASK, M_OWN, M_GIVE, M_DONE} mph_e;
  mph_e         m_ph = M_FREE;
  int           m_acks = 0;
  logic [W-1:0] m_base = '0;

  function automatic int m_index();
    return (m_acks < L) ? m_acks : L - 1;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_ph   <= M_FREE;
      m_acks <= 0;
      m_base <= '0;
    end else begin
      case (m_ph)
        M_FREE: if (cmd_valid) begin
          m_base <= cmd_addr;
          m_acks <= 0;
          m_ph   <= M_ASK;
        end
        M_ASK: if (bus_grant) m_ph <= M_OWN;
        M_OWN: if (bus_grant && mem_ack) begin
          m_acks <= m_acks + 1;
          if (m_acks == L - 1) m_ph <= M_GIVE;
        end
        M_GIVE: if (!bus_grant) m_ph <= M_DONE;
        default: m_ph <= M_FREE;
      endcase
    end
  end

  bit           chk_en = 0;
  logic [W-1:0] wr_addr[$];
  logic [W-1:0] wr_data[$];
  int           wcyc = 0;
  int           ends = 0;

  always @(negedge clk) begin : cmp
    int ix;
    bit ew;
    if (chk_en) begin
      ix = m_index();
      ew = (m_ph == M_OWN) && bus_grant;
      chk("busy", busy, m_ph != M_FREE);
      chk("bus_request", bus_request, (m_ph == M_ASK) || (m_ph == M_OWN));
      chk("mem_write", mem_write, ew);
      chk("dma_end", dma_end, m_ph == M_DONE);
      chk("dev_index", dev_index, ix);
      if (ew) begin
        chk("mem_addr", mem_addr, (int'(m_base) + ix) & 32'hFFFF);
        chk("mem_wdata", mem_wdata, (int'(dev_key) + ix) & 32'hFFFF);
      end
      if (mem_write && mem_ack) begin
        wr_addr.push_back(mem_addr);
        wr_data.push_back(mem_wdata);
      end
      if (mem_write) wcyc++;
      if (dma_end) ends++;
    end
  end

  // Arbiter / memory / noise environment.
  int g_dly = 2, r_dly = 1, ack_per = 1, rv_at = -1, rv_len = 4;
  bit ack_rand = 0, noise_en = 0, rv_done = 0;
  int gcnt = 0, rcnt = 0, rv = 0, wt = 0;

  initial forever begin
    @(posedge clk);
    #1;
    if (!reset_n) begin
      bus_grant = 0; mem_ack = 0;
      gcnt = 0; rcnt = 0; rv = 0; wt = 0;
    end else begin
      if (rv > 0) begin
        rv--;
        bus_grant = (rv == 0);
      end else if (rv_at >= 0 && !rv_done && m_ph == M_OWN &&
                   bus_grant && m_acks == rv_at) begin
        bus_grant = 0;
        rv = rv_len;
        rv_done = 1;
      end else if (bus_request) begin
        if (!bus_grant) begin
          if (gcnt >= g_dly) begin bus_grant = 1; gcnt = 0; end
          else gcnt++;
        end
      end else if (bus_grant) begin
        if (rcnt >= r_dly) begin bus_grant = 0; rcnt = 0; end
        else rcnt++;
      end
      if (m_ph == M_OWN && bus_grant) begin
        if (ack_rand) mem_ack = 1'($urandom_range(0, 1));
        else if (wt >= ack_per - 1) begin mem_ack = 1; wt = 0; end
        else begin mem_ack = 0; wt++; end
      end else begin
        // Stray acks while not writing must be ignored.
        mem_ack = 1'($urandom_range(0, 1));
        if (m_ph != M_OWN) wt = 0;
      end
    end
    #1;
    if (noise_en && reset_n) begin
      if (m_ph == M_ASK || m_ph == M_OWN || m_ph == M_GIVE) begin
        cmd_valid = 1'($urandom_range(0, 1));
        cmd_addr  = W'($urandom);
      end else if (m_ph == M_DONE) begin
        cmd_valid = 0;
      end
    end
  end

  task automatic do_reset();
    #1;
    reset_n = 0;
    cmd_valid = 0;
    #1;
    chk("rst bus_request", bus_request, 0);
    chk("rst busy", busy, 0);
    chk("rst mem_write", mem_write, 0);
    chk("rst dma_end", dma_end, 0);
    chk("rst dev_index", dev_index, 0);
    repeat (2) @(posedge clk);
    #3;
    reset_n = 1;
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
    wcyc = 0;
    ends = 0;
    rv_done = 0;
  endtask

  task automatic send_cmd(input logic [W-1:0] a);
    @(posedge clk);
    #1;
    clear_log();
    cmd_addr = a;
    cmd_valid = 1;
    @(posedge clk);
    #1;
    cmd_valid = 0;
  endtask

  task automatic wait_done(input string nm, input logic [W-1:0] b);
    int n;
    n = 0;
    while (ends == 0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    chk({nm, " finished"}, n < 3000, 1);
    chk({nm, " words"}, wr_addr.size(), L);
    chk({nm, " end pulses"}, ends, 1);
    if (wr_addr.size() == L) begin
      for (int i = 0; i < L; i++) begin
        chk($sformatf("%s addr%0d", nm, i), wr_addr[i],
            (int'(b) + i) & 32'hFFFF);
        chk($sformatf("%s data%0d", nm, i), wr_data[i],
            (int'(dev_key) + i) & 32'hFFFF);
      end
    end
  endtask

  initial begin : watchdog
    #2000000;
    fails++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin : main
    int n;
    do_reset();
    chk_en = 1;

    // Nominal transfer.
    send_cmd(16'h01F4);
    wait_done("nominal", 16'h01F4);
    chk("nom first addr", wr_addr[0], 16'h01F4);
    chk("nom first data", wr_data[0], 16'hA000);
    chk("nom last addr", wr_addr[L-1], 16'h01FF);
    chk("nom last data", wr_data[L-1], 16'hA00B);

    // Slow memory: ack every 3rd cycle.
    ack_per = 3;
    send_cmd(16'h01F4);
    wait_done("slow", 16'h01F4);
    chk("slow xfer cycles", wcyc, 36);
    ack_per = 1;

    // Grant revoked after the 5th ack for 4 cycles.
    rv_at = 5;
    rv_len = 4;
    send_cmd(16'h01F4);
    n = 0;
    while (!(m_ph == M_OWN && !bus_grant) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("revoke reached", n < 200, 1);
    chk("gap index", dev_index, 5);
    chk("gap write", mem_write, 0);
    while (!mem_write && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("resume addr", mem_addr, 16'h01F9);
    wait_done("revoke", 16'h01F4);
    rv_at = -1;

    // Address wrap.
    send_cmd(16'hFFFA);
    wait_done("wrap", 16'hFFFA);
    chk("wrap addr5", wr_addr[5], 16'hFFFF);
    chk("wrap addr6", wr_addr[6], 16'h0000);
    chk("wrap last", wr_addr[L-1], 16'h0005);

    // Reset after the 7th ack.
    send_cmd(16'h01F4);
    n = 0;
    while (m_acks < 7 && n < 300) begin
      @(posedge clk);
      n++;
    end
    chk("seven acks reached", n < 300, 1);
    do_reset();
    repeat (4) @(posedge clk);
    chk("no end after reset", ends, 0);
    send_cmd(16'h0100);
    wait_done("after reset", 16'h0100);
    chk("after reset first", wr_addr[0], 16'h0100);

    // Command ignored while busy, then back-to-back.
    send_cmd(16'h0200);
    n = 0;
    while (m_acks < 3 && n < 300) begin
      @(posedge clk);
      n++;
    end
    #1;
    cmd_addr = 16'h0300;
    cmd_valid = 1;
    @(posedge clk);
    #1;
    cmd_valid = 0;
    wait_done("busy cmd", 16'h0200);
    #1;
    clear_log();
    cmd_addr = 16'h0400;
    cmd_valid = 1;
    @(posedge clk);
    #1;
    cmd_valid = 0;
    chk("b2b accepted", bus_request, 1);
    wait_done("b2b", 16'h0400);
    chk("b2b first", wr_addr[0], 16'h0400);

    // Randomized transfers.
    for (int t = 0; t < 20; t++) begin
      logic [W-1:0] b;
      b = W'($urandom);
      dev_key  = W'($urandom);
      g_dly    = $urandom_range(0, 3);
      r_dly    = $urandom_range(0, 3);
      ack_rand = 1'($urandom_range(0, 1));
      ack_per  = $urandom_range(1, 3);
      rv_at    = $urandom_range(0, L) - 1;
      rv_len   = $urandom_range(1, 5);
      send_cmd(b);
      noise_en = 1;
      wait_done($sformatf("rand%0d", t), b);
      noise_en = 0;
      cmd_valid = 0;
    end

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
